// File: rtl/param_timestep_controller.sv
// Timestep controller: owns the T0..T3 sequence plus a HALT state and decodes the
// instruction register into per-timestep datapath controls.
module param_timestep_controller #(
  parameter int DATA_W     = 10,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     INST,
  input  logic                  exec,
  output logic [DATA_W-1:0]     IMM,
  output logic                  IMMout,
  output logic [REG_ADDR_W-1:0] Rin,
  output logic [REG_ADDR_W-1:0] Rout,
  output logic                  ENW,
  output logic                  ENR,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  Gout,
  output logic [3:0]            ALUcont,
  output logic                  Ext,
  output logic                  IRin,
  output logic                  Clr,
  output logic [1:0]            T,
  output logic                  busy,
  output logic                  halted
);

  localparam int IMM_W = DATA_W - 4 - REG_ADDR_W;
  localparam int RX_HI = DATA_W - 5;
  localparam int RY_HI = DATA_W - 5 - REG_ADDR_W;

  localparam logic [3:0] OP_LD     = 4'b0000;
  localparam logic [3:0] OP_CPY    = 4'b0001;
  localparam logic [3:0] OP_ALU_LO = 4'b0010;
  localparam logic [3:0] OP_ALU_HI = 4'b1011;
  localparam logic [3:0] OP_ADDI   = 4'b1100;
  localparam logic [3:0] OP_SUBI   = 4'b1101;
  localparam logic [3:0] OP_NOP    = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              op;
  logic [REG_ADDR_W-1:0]   rx;
  logic [REG_ADDR_W-1:0]   ry;
  logic                    is_alu;
  logic                    is_immop;

  assign op       = INST[DATA_W-1 -: 4];
  assign rx       = INST[RX_HI -: REG_ADDR_W];
  assign ry       = INST[RY_HI -: REG_ADDR_W];
  assign is_alu   = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  assign is_immop = (op == OP_ADDI) || (op == OP_SUBI);

  // ADDI/SUBI reuse the ADD/SUB encodings of the register-register ops.
  function automatic logic [3:0] alu_select(input logic [3:0] opc);
    logic [3:0] sel;
    sel = 4'd0;
    if ((opc >= OP_ALU_LO) && (opc <= OP_ALU_HI)) sel = opc - OP_ALU_LO;
    else if (opc == OP_SUBI)                      sel = 4'd1;
    return sel;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_T0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_T0:    state_nxt = exec ? S_T1 : S_T0;
      S_T1: begin
        if ((op == OP_LD) || (op == OP_CPY) || (op == OP_NOP)) state_nxt = S_T0;
        else if (op == OP_HALT)                                 state_nxt = S_HALT;
        else                                                    state_nxt = S_T2;
      end
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
  end

  // Outputs are forced low while reset is held, independent of state and exec.
  always_comb begin
    IMM     = '0;
    IMMout  = 1'b0;
    Rin     = '0;
    Rout    = '0;
    ENW     = 1'b0;
    ENR     = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    ALUcont = 4'd0;
    Ext     = 1'b0;
    IRin    = 1'b0;
    Clr     = 1'b0;
    T       = 2'd0;
    busy    = 1'b0;
    halted  = 1'b0;
    if (!rst) begin
      IMM = {{(DATA_W-IMM_W){1'b0}}, INST[IMM_W-1:0]};
      case (state)
        S_T0: begin
          IRin = exec;
          Ext  = exec;
        end
        S_T1: begin
          T    = 2'd1;
          busy = 1'b1;
          if (op == OP_LD) begin
            Ext = 1'b1;
            Rin = rx;
            ENW = 1'b1;
            Clr = 1'b1;
          end else if (op == OP_CPY) begin
            ENR  = 1'b1;
            Rout = ry;
            Rin  = rx;
            ENW  = 1'b1;
            Clr  = 1'b1;
          end else if ((op == OP_NOP) || (op == OP_HALT)) begin
            Clr = 1'b1;
          end else begin
            ENR  = 1'b1;
            Rout = rx;
            Ain  = 1'b1;
          end
        end
        S_T2: begin
          T       = 2'd2;
          busy    = 1'b1;
          ALUcont = alu_select(op);
          if (is_alu) begin
            ENR  = 1'b1;
            Rout = ry;
            Gin  = 1'b1;
          end else if (is_immop) begin
            IMMout = 1'b1;
            Gin    = 1'b1;
          end
        end
        S_T3: begin
          T       = 2'd3;
          busy    = 1'b1;
          ALUcont = alu_select(op);
          Gout    = 1'b1;
          Rin     = rx;
          ENW     = 1'b1;
          Clr     = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_param_timestep_controller.sv
// Scoreboarded bench for param_timestep_controller: a driver pushes the expected
// control word per cycle from an instruction-level model; a monitor pops and compares.
module tb_param_timestep_controller;

  localparam int DW    = 10;
  localparam int RA    = 2;
  localparam int IMM_W = DW - 4 - RA;

  typedef struct packed {
    logic [DW-1:0] imm;
    logic          immout;
    logic [RA-1:0] rin;
    logic [RA-1:0] rout;
    logic          enw;
    logic          enr;
    logic          ain;
    logic          gin;
    logic          gout;
    logic [3:0]    alucont;
    logic          ext;
    logic          irin;
    logic          clr;
    logic [1:0]    t;
    logic          busy;
    logic          halted;
  } ctl_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] INST;
  logic          exec;
  logic [DW-1:0] IMM;
  logic          IMMout;
  logic [RA-1:0] Rin;
  logic [RA-1:0] Rout;
  logic          ENW;
  logic          ENR;
  logic          Ain;
  logic          Gin;
  logic          Gout;
  logic [3:0]    ALUcont;
  logic          Ext;
  logic          IRin;
  logic          Clr;
  logic [1:0]    T;
  logic          busy;
  logic          halted;

  param_timestep_controller #(.DATA_W(DW), .REG_ADDR_W(RA)) dut (
    .clk(clk), .rst(rst), .INST(INST), .exec(exec),
    .IMM(IMM), .IMMout(IMMout), .Rin(Rin), .Rout(Rout),
    .ENW(ENW), .ENR(ENR), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .ALUcont(ALUcont), .Ext(Ext), .IRin(IRin), .Clr(Clr),
    .T(T), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mk = 0;       // model: timestep index within the current instruction
  bit            mh = 1'b0;    // model: halted
  logic [DW-1:0] cur_inst = '0;
  event          mid_chk;

  function automatic int op_of(input logic [DW-1:0] inst);
    return int'(inst[DW-1 -: 4]);
  endfunction

  // Instruction length in cycles including the fetch step.
  function automatic int len_of(input logic [DW-1:0] inst);
    int o;
    o = op_of(inst);
    return (o >= 2 && o <= 13) ? 4 : 2;
  endfunction

  function automatic ctl_t model_out(input int k, input bit hlt, input logic [DW-1:0] inst,
                                     input bit ex, input bit r);
    ctl_t e;
    int   o;
    bit   alu;
    bit   immop;
    e = '0;
    if (r) return e;
    e.imm[IMM_W-1:0] = inst[IMM_W-1:0];
    if (hlt) begin
      e.halted = 1'b1;
      return e;
    end
    o     = op_of(inst);
    alu   = (o >= 2) && (o <= 11);
    immop = (o == 12) || (o == 13);
    e.t    = 2'(k);
    e.busy = (k != 0);
    if (k == 0 && ex) begin
      e.irin = 1'b1;
      e.ext  = 1'b1;
    end
    if (k == 1) begin
      if (o == 0) begin
        e.ext = 1'b1; e.rin = inst[DW-5 -: RA]; e.enw = 1'b1;
      end else if (o == 1) begin
        e.enr = 1'b1; e.rout = inst[DW-5-RA -: RA]; e.rin = inst[DW-5 -: RA]; e.enw = 1'b1;
      end else if (alu || immop) begin
        e.enr = 1'b1; e.rout = inst[DW-5 -: RA]; e.ain = 1'b1;
      end
    end
    if (k == 2) begin
      e.gin = 1'b1;
      if (alu) begin
        e.enr = 1'b1; e.rout = inst[DW-5-RA -: RA];
      end else begin
        e.immout = 1'b1;
      end
    end
    if (k == 3) begin
      e.gout = 1'b1; e.rin = inst[DW-5 -: RA]; e.enw = 1'b1;
    end
    if (k >= 2) e.alucont = alu ? 4'(o - 2) : 4'(o - 12);
    if (k != 0 && k == len_of(inst) - 1) e.clr = 1'b1;
    return e;
  endfunction

  task automatic cycle(input bit r, input logic [DW-1:0] inst_v, input bit ex_v);
    @(posedge clk);
    #1;
    rst  = r;
    INST = inst_v;
    exec = ex_v;
    if (r) begin
      mk = 0;
      mh = 1'b0;
    end
    sb.push_back(model_out(mk, mh, inst_v, ex_v, r));
    if (!r && !mh) begin
      if (mk == 0) mk = ex_v ? 1 : 0;
      else if (mk == len_of(inst_v) - 1) begin
        mk = 0;
        if (op_of(inst_v) == 15) mh = 1'b1;
      end else mk = mk + 1;
    end
  endtask

  // Raise reset between clock edges and expect every output to drop at once.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    mk  = 0;
    mh  = 1'b0;
    #1;
    sb.push_back(model_out(0, 1'b0, INST, exec, 1'b1));
    ->mid_chk;
  endtask

  initial begin
    ctl_t a;
    ctl_t e;
    forever begin
      @(negedge clk or mid_chk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {IMM, IMMout, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, Ext, IRin, Clr, T, busy, halted};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctl t=%0t actual=%h required=%h", $time, a, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: stimulus did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  localparam logic [DW-1:0] I_LD   = 10'b0000_01_0000;
  localparam logic [DW-1:0] I_ADD  = 10'b0010_10_11_00;
  localparam logic [DW-1:0] I_SUBI = 10'b1101_01_0101;
  localparam logic [DW-1:0] I_HALT = 10'b1111_00_0000;
  localparam logic [DW-1:0] I_XOR  = 10'b1000_01_10_11;
  localparam logic [DW-1:0] I_CPY  = 10'b0001_11_01_10;

  initial begin
    int hcnt;
    rst  = 1'b1;
    INST = '0;
    exec = 1'b0;
    cycle(1'b1, '0, 1'b0);
    cycle(1'b1, '0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, I_LD, 1'b1);
    cycle(1'b0, I_LD, 1'b0);
    cycle(1'b0, I_LD, 1'b0);
    cycle(1'b0, I_LD, 1'b1);
    mid_reset();
    cycle(1'b0, I_LD, 1'b0);
    cycle(1'b0, I_ADD, 1'b1);
    repeat (3) cycle(1'b0, I_ADD, 1'b0);
    cycle(1'b0, I_SUBI, 1'b1);
    repeat (3) cycle(1'b0, I_SUBI, 1'b1);
    cycle(1'b0, I_CPY, 1'b1);
    cycle(1'b0, I_CPY, 1'b0);
    cycle(1'b0, I_HALT, 1'b1);
    cycle(1'b0, I_HALT, 1'b1);
    repeat (10) cycle(1'b0, I_HALT, 1'b1);
    cycle(1'b1, I_HALT, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, I_XOR, 1'b1);
    cycle(1'b0, I_XOR, 1'b0);
    cycle(1'b0, I_XOR, 1'b0);
    mid_reset();
    cycle(1'b1, I_XOR, 1'b1);
    cycle(1'b0, I_XOR, 1'b1);
    repeat (3) cycle(1'b0, I_XOR, 1'b0);

    hcnt = 0;
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          ev;
      logic [31:0] rv;
      r = ($urandom_range(0, 49) == 0) || (mh && hcnt >= 4);
      if (mh) hcnt++;
      else    hcnt = 0;
      if (mk == 0) begin
        rv       = $urandom;
        cur_inst = rv[DW-1:0];
      end
      ev = ($urandom_range(0, 3) != 0);
      cycle(r, cur_inst, ev);
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
